// File: rtl/float_to_fixed.sv
// rtl/float_to_fixed.sv - IEEE-754 single to signed fixed-point converter, 3-stage valid/ready pipeline; F2FX_ROUND_EN selects round-to-nearest-even
module float_to_fixed #(
  parameter int FRACTIONAL_BITS = 22,
  parameter int INT_BITS        = 1,
  parameter int OUT_W           = FRACTIONAL_BITS + INT_BITS + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_ovf
);

  // left-shift workspace: OUT_W bits of result plus room for the 24-bit significand to overflow into
  localparam int WIDE = OUT_W + 24;

  localparam logic signed [15:0] FB_S    = 16'(FRACTIONAL_BITS);
  localparam logic signed [15:0] OUT_W_S = 16'(OUT_W);

  localparam logic [OUT_W-1:0] MAX_OUT  = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] MIN_OUT  = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W:0]   MAX_MAG  = {2'b00, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W:0]   HALF_MAG = {2'b01, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {CLS_NORM, CLS_ZERO, CLS_INF, CLS_NAN} cls_e;

  logic s1_valid_q, s2_valid_q, s3_valid_q;
  logic s1_adv, s2_adv, s3_adv;

  // stage advance chain: a stage moves when empty or when its successor moves
  always_comb begin
    s3_adv   = !s3_valid_q || out_ready;
    s2_adv   = !s2_valid_q || s3_adv;
    s1_adv   = !s1_valid_q || s2_adv;
    in_ready = !reset && s1_adv;
  end

  assign out_valid = s3_valid_q;

  // per-stage valid bits; reset drops every in-flight sample
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
    end else begin
      if (s1_adv) s1_valid_q <= in_valid && in_ready;
      if (s2_adv) s2_valid_q <= s1_valid_q;
      if (s3_adv) s3_valid_q <= s2_valid_q;
    end
  end

  // ---------------- S1: unpack ----------------
  logic               s1_sign_d, s1_sign_q;
  logic [23:0]        s1_mant_d, s1_mant_q;
  logic signed [15:0] s1_sh_d, s1_sh_q;
  cls_e               s1_cls_d, s1_cls_q;

  // split fields, classify, and compute the signed shift that aligns the binary point
  always_comb begin
    s1_sign_d = in_data[31];
    s1_mant_d = {1'b1, in_data[22:0]};
    s1_sh_d   = $signed({8'd0, in_data[30:23]}) - 16'sd150 + FB_S;
    s1_cls_d  = CLS_NORM;
    if (in_data[30:23] == 8'd0)
      s1_cls_d = CLS_ZERO;
    else if (in_data[30:23] == 8'hFF)
      s1_cls_d = (in_data[22:0] == 23'd0) ? CLS_INF : CLS_NAN;
  end

  // S1 data register
  always_ff @(posedge clk) begin
    if (s1_adv) begin
      s1_sign_q <= s1_sign_d;
      s1_mant_q <= s1_mant_d;
      s1_sh_q   <= s1_sh_d;
      s1_cls_q  <= s1_cls_d;
    end
  end

  // ---------------- S2: shift ----------------
  logic             s2_sign_q;
  cls_e             s2_cls_q;
  logic [OUT_W-1:0] s2_mag_d, s2_mag_q;
  logic             s2_pre_ovf_d, s2_pre_ovf_q;
  logic [WIDE-1:0]  s2_wide;
  logic [15:0]      s2_rs;
`ifdef F2FX_ROUND_EN
  logic [49:0]      s2_rext;
  logic             s2_guard_d, s2_guard_q;
  logic             s2_sticky_d, s2_sticky_q;
`endif

  // align the significand; overflow is caught on the untruncated value
  always_comb begin
    s2_pre_ovf_d = 1'b0;
    s2_wide      = '0;
    s2_rs        = 16'(-s1_sh_q);
`ifdef F2FX_ROUND_EN
    s2_rext      = '0;
    s2_guard_d   = 1'b0;
    s2_sticky_d  = 1'b0;
`endif
    if (!s1_sh_q[15]) begin
      if (s1_sh_q >= OUT_W_S)
        s2_pre_ovf_d = 1'b1;
      else
        s2_wide = {{OUT_W{1'b0}}, s1_mant_q} << s1_sh_q;
    end else if (s2_rs >= 16'd26) begin
      // everything shifted out: zero magnitude, all significand bits fold into sticky
`ifdef F2FX_ROUND_EN
      s2_sticky_d = |s1_mant_q;
`endif
    end else begin
`ifdef F2FX_ROUND_EN
      s2_rext     = {s1_mant_q, 26'd0} >> s2_rs;
      s2_wide     = {{OUT_W{1'b0}}, s2_rext[49:26]};
      s2_guard_d  = s2_rext[25];
      s2_sticky_d = |s2_rext[24:0];
`else
      s2_wide = {{OUT_W{1'b0}}, s1_mant_q >> s2_rs};
`endif
    end
    if (|s2_wide[WIDE-1:OUT_W]) s2_pre_ovf_d = 1'b1;
    s2_mag_d = s2_wide[OUT_W-1:0];
  end

  // S2 data register
  always_ff @(posedge clk) begin
    if (s2_adv) begin
      s2_sign_q    <= s1_sign_q;
      s2_cls_q     <= s1_cls_q;
      s2_mag_q     <= s2_mag_d;
      s2_pre_ovf_q <= s2_pre_ovf_d;
`ifdef F2FX_ROUND_EN
      s2_guard_q   <= s2_guard_d;
      s2_sticky_q  <= s2_sticky_d;
`endif
    end
  end

  // ---------------- S3: round, negate, saturate ----------------
  logic [OUT_W:0]   s3_rmag;
  logic [OUT_W-1:0] s3_neg;
  logic [OUT_W-1:0] out_data_d, out_data_q;
  logic             out_ovf_d, out_ovf_q;
`ifdef F2FX_ROUND_EN
  logic             s3_rnd;
`endif

  // rounded magnitude is what gets range-checked, so a rounding carry can saturate
  always_comb begin
`ifdef F2FX_ROUND_EN
    s3_rnd  = s2_guard_q & (s2_sticky_q | s2_mag_q[0]);
    s3_rmag = {1'b0, s2_mag_q} + {{OUT_W{1'b0}}, s3_rnd};
`else
    s3_rmag = {1'b0, s2_mag_q};
`endif
    s3_neg     = -s3_rmag[OUT_W-1:0];
    out_data_d = '0;
    out_ovf_d  = 1'b0;
    case (s2_cls_q)
      CLS_ZERO: out_ovf_d = 1'b0;
      CLS_NAN:  out_ovf_d = 1'b1;
      CLS_INF: begin
        out_data_d = s2_sign_q ? MIN_OUT : MAX_OUT;
        out_ovf_d  = 1'b1;
      end
      default: begin
        if (!s2_sign_q) begin
          if (s2_pre_ovf_q || (s3_rmag > MAX_MAG)) begin
            out_data_d = MAX_OUT;
            out_ovf_d  = 1'b1;
          end else begin
            out_data_d = s3_rmag[OUT_W-1:0];
          end
        end else begin
          // magnitude of exactly 2^(OUT_W-1) negates cleanly to MIN without overflow
          if (s2_pre_ovf_q || (s3_rmag > HALF_MAG)) begin
            out_data_d = MIN_OUT;
            out_ovf_d  = 1'b1;
          end else begin
            out_data_d = s3_neg;
          end
        end
      end
    endcase
  end

  // output register: only loads a real sample so data holds while stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_q <= '0;
      out_ovf_q  <= 1'b0;
    end else if (s3_adv && s2_valid_q) begin
      out_data_q <= out_data_d;
      out_ovf_q  <= out_ovf_d;
    end
  end

  assign out_data = out_data_q;
  assign out_ovf  = out_ovf_q;

endmodule
